// File: rtl/block_ram_cfg_ctrl.sv
// rtl/block_ram_cfg_ctrl.sv - configurable-aspect-ratio block RAM tile with clear engine
//
// Ports:
//   clk, rst_n                    clock (rising edge) and asynchronous active-low reset
//   cfg_wr_mode, cfg_rd_mode      per-port width: 0 full, 1 half, 2 quarter, 3 full
//   cfg_out_reg                   1: extra output register, read latency 2
//   cfg_wr_always                 1: write port always enabled
//   clear_req                     pulse: zero the whole array
//   busy                          clear engine running
//   wr_en, wr_addr, wr_data       write port; wr_addr = {word, sub-word}
//   rd_en, rd_addr                read port; rd_addr = {word, sub-word}
//   rd_data, rd_valid             read result (narrow modes zero-extended) and its strobe
module block_ram_cfg_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cfg_wr_mode,
    input  logic [1:0]            cfg_rd_mode,
    input  logic                  cfg_out_reg,
    input  logic                  cfg_wr_always,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH+1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH+1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int LANE  = DATA_WIDTH / 4;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    clr_last;
    logic                    init_pend;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   wr_word;
    logic [1:0]              wr_sub;
    logic [ADDR_WIDTH-1:0]   rd_word;
    logic [1:0]              rd_sub;
    logic                    wr_fire;
    logic                    rd_fire;

    logic [3:0]              wr_lanes;
    logic [DATA_WIDTH-1:0]   wr_rep;
    logic [DATA_WIDTH-1:0]   wr_bits;
    logic [DATA_WIDTH-1:0]   wr_merged;
    logic [DATA_WIDTH-1:0]   rd_old;
    logic [DATA_WIDTH-1:0]   rd_merged;
    logic [DATA_WIDTH-1:0]   rd_sel;

    logic [DATA_WIDTH-1:0]   s1_data;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   s2_data;
    logic                    s2_valid;

    assign wr_word  = wr_addr[ADDR_WIDTH+1:2];
    assign wr_sub   = wr_addr[1:0];
    assign rd_word  = rd_addr[ADDR_WIDTH+1:2];
    assign rd_sub   = rd_addr[1:0];

    assign busy     = (state == ST_CLEAR);
    assign clr_last = (clr_cnt == {ADDR_WIDTH{1'b1}});

    // Both ports are locked out while the clear engine owns the array.
    assign wr_fire  = rst_n && (state == ST_IDLE) && (wr_en || cfg_wr_always);
    assign rd_fire  = (state == ST_IDLE) && rd_en;

    // Write lane mask and write data replicated into every lane position,
    // so the mask alone decides which lanes take new data.
    always_comb begin
        wr_lanes = 4'b1111;
        wr_rep   = wr_data;
        case (cfg_wr_mode)
            2'd1: begin
                wr_lanes = wr_sub[1] ? 4'b1100 : 4'b0011;
                wr_rep   = {2{wr_data[2*LANE-1:0]}};
            end
            2'd2: begin
                wr_lanes = 4'b0001 << wr_sub;
                wr_rep   = {4{wr_data[LANE-1:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_bits = '0;
        for (int i = 0; i < 4; i++) begin
            wr_bits[i*LANE +: LANE] = {LANE{wr_lanes[i]}};
        end
    end

    assign wr_merged = (mem[wr_word] & ~wr_bits) | (wr_rep & wr_bits);

    // Collision: with write-first, only the lanes being written show new data.
    assign rd_old = mem[rd_word];

    always_comb begin
        rd_merged = rd_old;
        if (WRITE_FIRST != 0 && wr_fire && (wr_word == rd_word)) begin
            rd_merged = (rd_old & ~wr_bits) | (wr_rep & wr_bits);
        end
    end

    // The sub-word mux is applied in the same cycle as the array read, so
    // the stored result already carries the right lanes; later stages just
    // move it along and cannot pair data with a stale select.
    always_comb begin
        rd_sel = rd_merged;
        case (cfg_rd_mode)
            2'd1: begin
                if (rd_sub[1]) begin
                    rd_sel = DATA_WIDTH'(rd_merged[4*LANE-1:2*LANE]);
                end else begin
                    rd_sel = DATA_WIDTH'(rd_merged[2*LANE-1:0]);
                end
            end
            2'd2: begin
                rd_sel = '0;
                for (int i = 0; i < 4; i++) begin
                    if (rd_sub == 2'(i)) begin
                        rd_sel = DATA_WIDTH'(rd_merged[i*LANE +: LANE]);
                    end
                end
            end
            default: ;
        endcase
    end

    // Array storage: no reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_fire) begin
            mem[wr_word] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clear_req || init_pend) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // init_pend requests one automatic clear on the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt   <= '0;
            init_pend <= 1'(CLEAR_ON_RESET != 0);
        end else begin
            init_pend <= 1'b0;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Read pipeline: stage 1 is the array read, stage 2 the optional output
    // register. Both keep running during a clear so in-flight reads drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s2_data  <= '0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_sel;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_data;
            end
        end
    end

    assign rd_data  = cfg_out_reg ? s2_data  : s1_data;
    assign rd_valid = cfg_out_reg ? s2_valid : s1_valid;

endmodule

// File: tb/tb_block_ram_cfg_ctrl.sv
// tb/tb_block_ram_cfg_ctrl.sv - directed-vector bench for block_ram_cfg_ctrl
module tb_block_ram_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_wr_mode;
    logic [1:0]  cfg_rd_mode;
    logic        cfg_out_reg;
    logic        cfg_wr_always;
    logic        clear_req;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [9:0]  rd_addr;

    logic        busy0, busy1;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    block_ram_cfg_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_rf (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_mode(cfg_wr_mode), .cfg_rd_mode(cfg_rd_mode),
        .cfg_out_reg(cfg_out_reg), .cfg_wr_always(cfg_wr_always),
        .clear_req(clear_req), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    block_ram_cfg_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_wf (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_mode(cfg_wr_mode), .cfg_rd_mode(cfg_rd_mode),
        .cfg_out_reg(cfg_out_reg), .cfg_wr_always(cfg_wr_always),
        .clear_req(clear_req), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] word, input logic [1:0] sub,
                            input logic [1:0] mode, input logic [31:0] data);
        cfg_wr_mode = mode;
        wr_addr     = {word, sub};
        wr_data     = data;
        wr_en       = 1'b1;
        tick();
        wr_en       = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] word, input logic [1:0] sub,
                            input logic [1:0] mode, input logic [31:0] exp);
        int lat;
        cfg_rd_mode = mode;
        rd_addr     = {word, sub};
        rd_en       = 1'b1;
        tick();
        rd_en       = 1'b0;
        lat         = 1;
        while (!rd_valid0 && lat < 4) begin
            tick();
            lat++;
        end
        check_vec({tag, "_lat"}, 32'(lat), cfg_out_reg ? 32'd2 : 32'd1);
        check_vec({tag, "_rf"}, rd_data0, exp);
        check_vec({tag, "_wf"}, rd_data1, exp);
        tick();
        check_vec({tag, "_pulse"}, {31'd0, rd_valid0}, 32'd0);
    endtask

    // Waits for busy to rise, then counts busy cycles. With abuse set, wr_en
    // and rd_en are held high on word 30 throughout and any rd_valid is counted.
    task automatic count_busy(input bit abuse, output int n, output int stray_valid);
        int guard;
        guard       = 0;
        n           = 0;
        stray_valid = 0;
        while (!busy0 && guard < 10) begin
            tick();
            guard++;
        end
        if (abuse) begin
            cfg_wr_mode = 2'd0;
            wr_addr     = {8'd30, 2'd0};
            wr_data     = 32'h7777_7777;
            wr_en       = 1'b1;
            rd_addr     = {8'd30, 2'd0};
            rd_en       = 1'b1;
        end
        while (busy0 && n < 1000) begin
            n++;
            tick();
            if (rd_valid0 || rd_valid1) stray_valid++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int stray;

        rst_n         = 1'b0;
        cfg_wr_mode   = 2'd0;
        cfg_rd_mode   = 2'd0;
        cfg_out_reg   = 1'b0;
        cfg_wr_always = 1'b0;
        clear_req     = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        rd_en         = 1'b0;
        rd_addr       = '0;

        repeat (3) tick();
        check_vec("rst_busy", {31'd0, busy0}, 32'd0);
        check_vec("rst_valid", {31'd0, rd_valid0}, 32'd0);
        check_vec("rst_data", rd_data0, 32'd0);

        rst_n = 1'b1;
        count_busy(1'b0, n, stray);
        check_vec("init_busy_len", 32'(n), 32'd256);
        check_vec("init_busy_len_wf", {31'd0, busy1}, 32'd0);

        read_chk("clr_w0", 8'd0, 2'd0, 2'd0, 32'h0);
        read_chk("clr_w255", 8'd255, 2'd0, 2'd0, 32'h0);

        do_write(8'd5, 2'd0, 2'd0, 32'hDEAD_BEEF);
        read_chk("full_w5", 8'd5, 2'd0, 2'd0, 32'hDEAD_BEEF);
        cfg_out_reg = 1'b1;
        read_chk("full_w5_oreg", 8'd5, 2'd0, 2'd0, 32'hDEAD_BEEF);
        cfg_out_reg = 1'b0;

        do_write(8'd9, 2'd0, 2'd2, 32'h0000_0011);
        do_write(8'd9, 2'd1, 2'd2, 32'h0000_0022);
        do_write(8'd9, 2'd2, 2'd2, 32'h0000_0033);
        do_write(8'd9, 2'd3, 2'd2, 32'h0000_0044);
        read_chk("q_full", 8'd9, 2'd0, 2'd0, 32'h4433_2211);
        read_chk("q_half2", 8'd9, 2'd2, 2'd1, 32'h0000_4433);
        read_chk("q_half0", 8'd9, 2'd1, 2'd1, 32'h0000_2211);
        read_chk("q_qtr1", 8'd9, 2'd1, 2'd2, 32'h0000_0022);
        read_chk("q_qtr3", 8'd9, 2'd3, 2'd2, 32'h0000_0044);
        cfg_out_reg = 1'b1;
        read_chk("q_qtr2_oreg", 8'd9, 2'd2, 2'd2, 32'h0000_0033);
        cfg_out_reg = 1'b0;

        do_write(8'd12, 2'd3, 2'd1, 32'hFFFF_BEEF);
        read_chk("h_w12", 8'd12, 2'd0, 2'd0, 32'hBEEF_0000);

        // Full-word collision on word 3.
        do_write(8'd3, 2'd0, 2'd0, 32'hAAAA_AAAA);
        cfg_wr_mode = 2'd0;
        cfg_rd_mode = 2'd0;
        wr_addr     = {8'd3, 2'd0};
        wr_data     = 32'h5555_5555;
        rd_addr     = {8'd3, 2'd0};
        wr_en       = 1'b1;
        rd_en       = 1'b1;
        tick();
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        check_vec("col_full_rf", rd_data0, 32'hAAAA_AAAA);
        check_vec("col_full_wf", rd_data1, 32'h5555_5555);

        // Half-word collision on lanes 2-3.
        do_write(8'd3, 2'd0, 2'd0, 32'hAAAA_AAAA);
        cfg_wr_mode = 2'd1;
        cfg_rd_mode = 2'd0;
        wr_addr     = {8'd3, 2'd2};
        wr_data     = 32'h0000_5555;
        rd_addr     = {8'd3, 2'd0};
        wr_en       = 1'b1;
        rd_en       = 1'b1;
        tick();
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        check_vec("col_half_rf", rd_data0, 32'hAAAA_AAAA);
        check_vec("col_half_wf", rd_data1, 32'h5555_AAAA);
        read_chk("col_half_after", 8'd3, 2'd0, 2'd0, 32'h5555_AAAA);

        // Write port forced on with wr_en low.
        cfg_wr_mode   = 2'd0;
        wr_addr       = {8'd7, 2'd0};
        wr_data       = 32'h1234_5678;
        cfg_wr_always = 1'b1;
        tick();
        cfg_wr_always = 1'b0;
        read_chk("wr_always", 8'd7, 2'd0, 2'd0, 32'h1234_5678);

        // Clear interrupted by reset at cycle 100, then automatic restart.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 1;
        while (busy0 && n < 100) begin
            tick();
            n++;
        end
        check_vec("mid_busy_at100", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check_vec("mid_rst_valid", {31'd0, rd_valid0}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        count_busy(1'b1, n, stray);
        check_vec("restart_busy_len", 32'(n), 32'd256);
        check_vec("restart_no_valid", 32'(stray), 32'd0);
        read_chk("restart_w30", 8'd30, 2'd0, 2'd0, 32'h0);
        read_chk("restart_w5", 8'd5, 2'd0, 2'd0, 32'h0);
        read_chk("restart_w200", 8'd200, 2'd0, 2'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
